rb_write_ctrl: RTL

RB_WRITE_CTRL -- requirements
Module: rb_write_ctrl

---
 rtl/rb_write_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/rb_write_ctrl.sv
// Write-port controller for one SIMT register bank: zero-fills the bank after reset,
// then round-robin arbitrates ALU and memory-load writebacks onto a single registered write port.
module rb_write_ctrl #(
  parameter int   LANES   = 16,
  parameter int   DATA_W  = 64,
  parameter int   NREGS   = 32,
  parameter bit   INIT_EN = 1'b1,
  localparam int  ADDR_W  = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [ADDR_W-1:0]       a_addr,
  input  logic [LANES-1:0]        a_mask,
  input  logic [LANES*DATA_W-1:0] a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [ADDR_W-1:0]       b_addr,
  input  logic [LANES-1:0]        b_mask,
  input  logic [LANES*DATA_W-1:0] b_data,
  output logic [LANES-1:0]        write_en,
  output logic [ADDR_W-1:0]       waddr,
  output logic [LANES*DATA_W-1:0] wdata,
  output logic                    init_done,
  output logic                    busy
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic {GR_A, GR_B} grant_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_t                  state, state_nxt;
  grant_t                  last_grant, last_grant_nxt;
  logic [ADDR_W-1:0]       cnt, cnt_nxt;
  logic [LANES-1:0]        write_en_nxt;
  logic [ADDR_W-1:0]       waddr_nxt;
  logic [LANES*DATA_W-1:0] wdata_nxt;
  logic                    init_done_nxt;

  // On a tie the requester that was not granted most recently wins.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state == ST_RUN) begin
      a_ready = a_valid && (!b_valid || (last_grant == GR_B));
      b_ready = b_valid && (!a_valid || (last_grant == GR_A));
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    write_en_nxt   = '0;
    waddr_nxt      = waddr;
    wdata_nxt      = wdata;
    init_done_nxt  = (state == ST_RUN);
    unique case (state)
      ST_INIT: begin
        write_en_nxt = '1;
        waddr_nxt    = cnt;
        wdata_nxt    = '0;
        cnt_nxt      = cnt + 1'b1;
        if (cnt == LAST_ADDR) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A zero mask is still a transfer: it moves the pointer but writes no lane.
        if (a_ready) begin
          write_en_nxt   = a_mask;
          waddr_nxt      = a_addr;
          wdata_nxt      = a_data;
          last_grant_nxt = GR_A;
        end else if (b_ready) begin
          write_en_nxt   = b_mask;
          waddr_nxt      = b_addr;
          wdata_nxt      = b_data;
          last_grant_nxt = GR_B;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT_EN ? ST_INIT : ST_RUN;
    else        state <= state_nxt;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      last_grant <= GR_B;
      write_en   <= '0;
      waddr      <= '0;
      // NOTE: the wide data register is reset too, because the port must read 0 during reset.
      wdata      <= '0;
      init_done  <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      write_en   <= write_en_nxt;
      waddr      <= waddr_nxt;
      wdata      <= wdata_nxt;
      init_done  <= init_done_nxt;
    end
  end

  assign busy = |write_en;

endmodule
